seg_scan_driver: RTL and testbench

//  Downstream consumer of the AXI4-Lite seg-show register file: converts the four slave registers
//  (value, digit enable, decimal points, control) into time-multiplexed anode/segment drive for an
//  8-digit common-anode 7-segment display. Registers are shadowed at frame boundaries (no tearing);

---
 rtl/seg_scan_driver.sv | 191 +++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver fed from the seg-show register file.
// Optional per-digit blinking is compiled in with `define SEG_BLINK_EN.

module seg_digit_lane (
  input  logic [3:0] nib,
  input  logic       en,
  input  logic       lz,
  input  logic       blink_off,
  output logic       vis,
  output logic [6:0] pat
);
  always_comb begin
    vis = en & ~lz & ~blink_off;
    pat = 7'h00;
    case (nib)
      4'h0: pat = 7'h3F;  4'h1: pat = 7'h06;  4'h2: pat = 7'h5B;  4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;  4'h5: pat = 7'h6D;  4'h6: pat = 7'h7D;  4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;  4'h9: pat = 7'h6F;  4'hA: pat = 7'h77;  4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;  4'hD: pat = 7'h5E;  4'hE: pat = 7'h79;  4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end
endmodule

module seg_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int GUARD_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLINK_FRAMES   = 250
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [4*NUM_DIGITS-1:0] disp_value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [31:0]             ctrl,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic POL = (SEG_ACTIVE_LOW != 0);
  // XOR masks: the "off" code for each output, also used to flip active-high into drive polarity
  localparam logic [6:0]            SEG_OFF = {7{POL}};
  localparam logic                  DP_OFF  = POL;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

  logic          en, en_d, load, tick, wrap;
  logic [PW-1:0] pc;
  logic [IW-1:0] idx;

  logic [NUM_DIGITS-1:0][3:0] sh_val, v_val;
  logic [NUM_DIGITS-1:0]      sh_en, sh_dp, v_en, v_dp, lz, blink_off, vis;
  logic [NUM_DIGITS-1:0][6:0] pat;
  logic                       sh_lz, v_lz;

  logic [NUM_DIGITS-1:0] an_act;
  logic [6:0]            seg_act;
  logic                  dp_act;

  assign en   = ctrl[0];
  assign load = en & ~en_d;
  assign tick = en && (pc == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pc   <= '0;
      idx  <= '0;
      en_d <= 1'b0;
    end else begin
      en_d <= en;
      if (!en) begin
        pc  <= '0;
        idx <= '0;
      end else if (tick) begin
        pc  <= '0;
        idx <= wrap ? '0 : idx + 1'b1;
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sh_val <= '0;
      sh_en  <= '0;
      sh_dp  <= '0;
      sh_lz  <= 1'b0;
    end else if (load || wrap) begin
      sh_val <= disp_value;
      sh_en  <= digit_en;
      sh_dp  <= dp_mask;
      sh_lz  <= ctrl[1];
    end
  end

  // On the enable edge the fresh registers must already drive the digit-0 slot
  assign v_val = load ? disp_value : sh_val;
  assign v_en  = load ? digit_en   : sh_en;
  assign v_dp  = load ? dp_mask    : sh_dp;
  assign v_lz  = load ? ctrl[1]    : sh_lz;

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] fcnt;
  logic          phase;
  logic [7:0]    sh_blink, v_blink;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)             sh_blink <= '0;
    else if (load || wrap)  sh_blink <= ctrl[15:8];
  end

  assign v_blink = load ? ctrl[15:8] : sh_blink;
`endif

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    logic upper_zero;
    always_comb begin
      upper_zero = 1'b1;
      for (int j = k; j < NUM_DIGITS; j++) upper_zero &= (v_val[j] == 4'h0);
    end
    // Digit 0 always shows, so a zero value still reads "0"
    assign lz[k] = (k != 0) && v_lz && upper_zero;
`ifdef SEG_BLINK_EN
    if (k < 8) begin : g_blink
      assign blink_off[k] = phase & v_blink[k];
    end else begin : g_noblink
      assign blink_off[k] = 1'b0;
    end
`else
    assign blink_off[k] = 1'b0;
`endif
    seg_digit_lane u_lane (
      .nib       (v_val[k]),
      .en        (v_en[k]),
      .lz        (lz[k]),
      .blink_off (blink_off[k]),
      .vis       (vis[k]),
      .pat       (pat[k])
    );
  end

  always_comb begin
    an_act = '0;
    if (vis[idx] && pc >= PW'(GUARD_CYC)) an_act[idx] = 1'b1;
    seg_act = vis[idx] ? pat[idx] : 7'h00;
    dp_act  = vis[idx] & v_dp[idx];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      seg_n      <= SEG_OFF;
      dp_n       <= DP_OFF;
      an_n       <= AN_OFF;
      frame_done <= 1'b0;
    end else if (!en) begin
      seg_n      <= SEG_OFF;
      dp_n       <= DP_OFF;
      an_n       <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= seg_act ^ SEG_OFF;
      dp_n       <= dp_act ^ DP_OFF;
      an_n       <= an_act ^ AN_OFF;
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a cycle model pushes expected outputs, compared after each edge,
// plus spot checks of the documented display patterns.
module tb_seg_scan_driver;
  localparam int ND = 8, SD = 4, GC = 1, BF = 2;
`ifdef SEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        ACLK = 1'b0, ARESET = 1'b0;
  logic [31:0] disp_value = '0, ctrl = '0;
  logic [7:0]  digit_en = '0, dp_mask = '0;
  logic [6:0]  seg_n;
  logic        dp_n, frame_done;
  logic [7:0]  an_n;

  always #5 ACLK = ~ACLK;

  seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYC(GC), .SEG_ACTIVE_LOW(1),
                    .BLINK_FRAMES(BF)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .disp_value(disp_value), .digit_en(digit_en),
    .dp_mask(dp_mask), .ctrl(ctrl), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .frame_done(frame_done));

  logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int   n_cmp = 0, n_err = 0;
  exp_t sb[$];

  int          m_pc, m_idx, m_fc;
  bit          m_en_d, m_ph, m_lz;
  logic [31:0] m_val;
  logic [7:0]  m_en, m_dp, m_bl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_an"}, an_n, 8'hFF);
    chk({tag, "_seg"}, seg_n, 7'h7F);
    chk({tag, "_dp"}, dp_n, 1'b1);
    chk({tag, "_fd"}, frame_done, 1'b0);
  endtask

  task automatic model_reset();
    m_pc = 0; m_idx = 0; m_fc = 0; m_en_d = 0; m_ph = 0;
    m_val = '0; m_en = '0; m_dp = '0; m_lz = 0; m_bl = '0;
  endtask

  task automatic model_load();
    m_val = disp_value; m_en = digit_en; m_dp = dp_mask; m_lz = ctrl[1]; m_bl = ctrl[15:8];
  endtask

  // One clock: predict the post-edge outputs, push, clock, pop and compare
  task automatic step();
    exp_t e, g;
    int   nib;
    bit   lzb, blk, vis;
    e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
    if (ARESET) begin
      model_reset();
    end else if (!ctrl[0]) begin
      m_pc = 0; m_idx = 0; m_fc = 0; m_en_d = 0; m_ph = 0;
    end else begin
      if (!m_en_d) model_load();
      nib = int'((m_val >> (4 * m_idx)) & 32'hF);
      lzb = m_lz && (m_idx != 0) && ((m_val >> (4 * m_idx)) == 32'h0);
      blk = BLINK && m_ph && m_bl[m_idx];
      vis = m_en[m_idx] && !lzb && !blk;
      e.seg = vis ? ~DEC[nib] : 7'h7F;
      e.dp  = !(vis && m_dp[m_idx]);
      e.an  = (vis && m_pc >= GC) ? ~(8'h01 << m_idx) : 8'hFF;
      e.fd  = (m_pc == SD - 1) && (m_idx == ND - 1);
      m_en_d = 1;
      if (m_pc == SD - 1) begin
        m_pc = 0;
        if (m_idx == ND - 1) begin
          m_idx = 0;
          model_load();
          m_fc = m_fc + 1;
          if (m_fc == BF) begin m_fc = 0; m_ph = ~m_ph; end
        end else m_idx = m_idx + 1;
      end else m_pc = m_pc + 1;
    end
    sb.push_back(e);
    @(posedge ACLK); #1;
    g = sb.pop_front();
    chk("sb_an", an_n, g.an);
    chk("sb_seg", seg_n, g.seg);
    chk("sb_dp", dp_n, g.dp);
    chk("sb_fd", frame_done, g.fd);
  endtask

  initial begin
    model_reset();
    // Reset and idle with enable low
    ARESET = 1'b1;
    #2;
    chk_off("rst");
    step(); step();
    ARESET = 1'b0;
    repeat (3) step();
    chk_off("idle");

    // Full-value scan, decimal point on digit 0
    disp_value = 32'h89AB_CDEF; digit_en = 8'hFF; dp_mask = 8'h01; ctrl = 32'h1;
    for (int s = 1; s <= 64; s++) begin
      step();
      case (s)
        1:  begin chk("s0_guard_an", an_n, 8'hFF); chk("s0_seg", seg_n, 7'h0E); chk("s0_dp", dp_n, 1'b0); end
        2:  chk("s0_an", an_n, 8'hFE);
        30: begin chk("s7_an", an_n, 8'h7F); chk("s7_seg", seg_n, 7'h00); chk("s7_dp", dp_n, 1'b1); end
        31: chk("fd_low", frame_done, 1'b0);
        32: chk("fd_1", frame_done, 1'b1);
        33: chk("fd_pulse", frame_done, 1'b0);
        64: chk("fd_2", frame_done, 1'b1);
        default: ;
      endcase
    end

    // Leading-zero blanking
    ctrl = 32'h0; step();
    disp_value = 32'h0000_00A0; dp_mask = 8'h00; ctrl = 32'h3;
    for (int s = 1; s <= 40; s++) begin
      step();
      case (s)
        1:  chk("lz_d0_seg", seg_n, 7'h40);
        2:  chk("lz_d0_an", an_n, 8'hFE);
        5:  chk("lz_d1_seg", seg_n, 7'h08);
        6:  chk("lz_d1_an", an_n, 8'hFD);
        10: begin chk("lz_d2_an", an_n, 8'hFF); chk("lz_d2_seg", seg_n, 7'h7F); end
        30: chk("lz_d7_an", an_n, 8'hFF);
        default: ;
      endcase
    end

    // Mid-frame value change is deferred to the next frame
    ctrl = 32'h0; step();
    disp_value = 32'h1111_1111; ctrl = 32'h1;
    for (int s = 1; s <= 40; s++) begin
      step();
      case (s)
        14: chk("sh_old_s3", seg_n, 7'h79);
        30: chk("sh_old_s7", seg_n, 7'h79);
        32: chk("sh_fd", frame_done, 1'b1);
        33: chk("sh_new_s0", seg_n, 7'h24);
        34: chk("sh_new_an", an_n, 8'hFE);
        default: ;
      endcase
      if (s == 13) disp_value = 32'h2222_2222;
    end

    // Disable during slot 5, then restart at digit 0
    ctrl = 32'h0; step();
    ctrl = 32'h1;
    repeat (21) step();
    chk("dis_pre_an", an_n, 8'hFF);
    ctrl = 32'h0;
    step(); chk_off("dis1");
    step(); chk_off("dis2");
    ctrl = 32'h1;
    step(); chk("ren_guard_an", an_n, 8'hFF); chk("ren_seg", seg_n, 7'h24);
    step(); chk("ren_an", an_n, 8'hFE);

    // Asynchronous reset mid-scan
    repeat (10) step();
    #2 ARESET = 1'b1;
    #1 chk_off("arst");
    model_reset();
    step();
    ARESET = 1'b0;
    step(); chk("arst_guard_an", an_n, 8'hFF); chk("arst_seg", seg_n, 7'h24);
    step(); chk("arst_an", an_n, 8'hFE);

    // Blink mask on digit 0 (ignored when the blink feature is absent)
    ctrl = 32'h0; step();
    disp_value = 32'h0; ctrl = 32'h0000_0101;
    for (int s = 1; s <= 160; s++) begin
      step();
      if ((s - 1) % 32 == 1)
        chk("blink_d0_an", an_n, (BLINK && ((s - 1) / 32 == 2 || (s - 1) / 32 == 3)) ? 8'hFF : 8'hFE);
      if ((s - 1) % 32 == 5)
        chk("blink_d1_an", an_n, 8'hFD);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
